// File: rtl/br_lite_local_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | BrLitePkg                                                                   |
// | Shared BrLite flit/service types plus the PE-side TX request entry.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package BrLitePkg;

    localparam int BR_ADDR_W    = 16;
    localparam int BR_ID_W      = 8;
    localparam int BR_SVC_W     = 2;
    localparam int BR_PAYLOAD_W = 32;

    localparam logic [BR_SVC_W-1:0] BR_SVC_ALL   = 2'd0;
    localparam logic [BR_SVC_W-1:0] BR_SVC_TGT   = 2'd1;
    localparam logic [BR_SVC_W-1:0] BR_SVC_MON   = 2'd2;
    localparam logic [BR_SVC_W-1:0] BR_SVC_CLEAR = 2'd3;

    typedef struct packed {
        logic [BR_ADDR_W-1:0]    seq_source;
        logic [BR_ADDR_W-1:0]    seq_target;
        logic [BR_ID_W-1:0]      id;
        logic [BR_SVC_W-1:0]     service;
        logic [BR_PAYLOAD_W-1:0] payload;
    } br_data_t;

    typedef struct packed {
        logic [BR_SVC_W-1:0]     service;
        logic [BR_ADDR_W-1:0]    target;
        logic [BR_PAYLOAD_W-1:0] payload;
    } br_tx_req_t;

    localparam int BR_DATA_W   = $bits(br_data_t);
    localparam int BR_TX_REQ_W = $bits(br_tx_req_t);

endpackage
`default_nettype wire

// File: rtl/br_lite_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | br_lite_fifo                                                                |
// | Synchronous FIFO, async active-low reset, head visible combinationally.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module br_lite_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/br_lite_local_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | br_lite_local_if                                                            |
// | PE-side BrLite local port: TX request queue/injector and RX delivery queue. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module br_lite_local_if
    import BrLitePkg::*;
#(
    parameter logic [BR_ADDR_W-1:0] SEQ_ADDRESS = 16'h0,
    parameter int                   TX_DEPTH    = 4,
    parameter int                   RX_DEPTH    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    input  logic [BR_SVC_W-1:0]     tx_service_i,
    input  logic [BR_ADDR_W-1:0]    tx_target_i,
    input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
    output logic                    tx_drop_o,
    output logic                    rx_valid_o,
    input  logic                    rx_ready_i,
    output logic [BR_DATA_W-1:0]    rx_data_o,
    output logic [BR_DATA_W-1:0]    br_flit_o,
    output logic                    br_req_o,
    input  logic                    br_ack_i,
    input  logic                    br_local_busy_i,
    input  logic [BR_DATA_W-1:0]    br_flit_i,
    input  logic                    br_req_i,
    output logic                    br_ack_o
);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;

    localparam logic RX_IDLE = 1'b0;
    localparam logic RX_ACK  = 1'b1;

    // ---------------- TX path ----------------
    logic [1:0]             r_tx_state;
    logic [1:0]             w_tx_state_nxt;
    logic [BR_ID_W-1:0]     r_next_id;
    logic [BR_DATA_W-1:0]   r_flit;
    logic                   r_tx_drop;
    logic                   w_enq;
    logic                   w_tx_push;
    logic                   w_tx_pop;
    logic                   w_tx_launch;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic [BR_TX_REQ_W-1:0] w_tx_rd_data;
    br_tx_req_t             w_tx_wr;
    br_tx_req_t             w_tx_head;
    br_data_t               w_tx_flit;

    assign tx_ready_o = !w_tx_full;
    assign w_enq      = tx_valid_i && tx_ready_o;
    assign w_tx_push  = w_enq && (tx_service_i != BR_SVC_CLEAR);

    assign w_tx_wr.service = tx_service_i;
    assign w_tx_wr.target  = tx_target_i;
    assign w_tx_wr.payload = tx_payload_i;
    assign w_tx_head       = w_tx_rd_data;

    br_lite_fifo #(
        .WIDTH (BR_TX_REQ_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (w_tx_push),
        .wr_data (w_tx_wr),
        .pop     (w_tx_pop),
        .rd_data (w_tx_rd_data),
        .full    (w_tx_full),
        .empty   (w_tx_empty)
    );

    always_comb begin
        w_tx_flit.seq_source = SEQ_ADDRESS;
        w_tx_flit.seq_target = w_tx_head.target;
        w_tx_flit.id         = r_next_id;
        w_tx_flit.service    = w_tx_head.service;
        w_tx_flit.payload    = w_tx_head.payload;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_tx_state <= TX_IDLE;
        else         r_tx_state <= w_tx_state_nxt;
    end

    // Busy only gates the launch decision; an in-flight handshake always completes
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (!w_tx_empty && !br_local_busy_i) w_tx_state_nxt = TX_REQ;
            TX_REQ:  if (br_ack_i)                        w_tx_state_nxt = TX_WAIT;
            TX_WAIT: if (!br_ack_i)                       w_tx_state_nxt = TX_IDLE;
            default:                                      w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        br_req_o    = (r_tx_state == TX_REQ);
        w_tx_launch = (r_tx_state == TX_IDLE) && !w_tx_empty && !br_local_busy_i;
        w_tx_pop    = (r_tx_state == TX_WAIT) && !br_ack_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flit    <= '0;
            r_next_id <= '0;
            r_tx_drop <= 1'b0;
        end else begin
            r_tx_drop <= w_enq && (tx_service_i == BR_SVC_CLEAR);
            if (w_tx_launch) r_flit    <= w_tx_flit;
            if (w_tx_pop)    r_next_id <= r_next_id + 1'b1;
        end
    end

    assign br_flit_o = r_flit;
    assign tx_drop_o = r_tx_drop;

    // ---------------- RX path ----------------
    logic                 r_rx_state;
    logic                 w_rx_state_nxt;
    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic [BR_DATA_W-1:0] w_rx_head;

    br_lite_fifo #(
        .WIDTH (BR_DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (w_rx_push),
        .wr_data (br_flit_i),
        .pop     (w_rx_pop),
        .rd_data (w_rx_head),
        .full    (w_rx_full),
        .empty   (w_rx_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE: if (br_req_i && !w_rx_full) w_rx_state_nxt = RX_ACK;
            RX_ACK:  if (!br_req_i)              w_rx_state_nxt = RX_IDLE;
            default:                             w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // Capture happens only on the IDLE->ACK edge, so a long req never double-pushes
    always_comb begin
        br_ack_o   = (r_rx_state == RX_ACK);
        w_rx_push  = (r_rx_state == RX_IDLE) && br_req_i && !w_rx_full;
        w_rx_pop   = rx_ready_i && !w_rx_empty;
        rx_valid_o = !w_rx_empty;
        rx_data_o  = w_rx_empty ? '0 : w_rx_head;
    end

endmodule
`default_nettype wire

// File: tb/tb_br_lite_local_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_br_lite_local_if                                                         |
// | Directed self-checking bench for the BrLite PE local port.                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_br_lite_local_if;
    import BrLitePkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    tx_valid_i;
    logic                    tx_ready_o;
    logic [BR_SVC_W-1:0]     tx_service_i;
    logic [BR_ADDR_W-1:0]    tx_target_i;
    logic [BR_PAYLOAD_W-1:0] tx_payload_i;
    logic                    tx_drop_o;
    logic                    rx_valid_o;
    logic                    rx_ready_i;
    logic [BR_DATA_W-1:0]    rx_data_o;
    logic [BR_DATA_W-1:0]    br_flit_o;
    logic                    br_req_o;
    logic                    br_ack_i;
    logic                    br_local_busy_i;
    logic [BR_DATA_W-1:0]    br_flit_i;
    logic                    br_req_i;
    logic                    br_ack_o;

    int n_tests = 0;
    int n_fail  = 0;

    br_lite_local_if #(
        .SEQ_ADDRESS (16'd5),
        .TX_DEPTH    (4),
        .RX_DEPTH    (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_service_i    (tx_service_i),
        .tx_target_i     (tx_target_i),
        .tx_payload_i    (tx_payload_i),
        .tx_drop_o       (tx_drop_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .rx_data_o       (rx_data_o),
        .br_flit_o       (br_flit_o),
        .br_req_o        (br_req_o),
        .br_ack_i        (br_ack_i),
        .br_local_busy_i (br_local_busy_i),
        .br_flit_i       (br_flit_i),
        .br_req_i        (br_req_i),
        .br_ack_o        (br_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BR_DATA_W-1:0] mk(input logic [15:0] src, input logic [15:0] tgt,
                                                input logic [7:0] id, input logic [1:0] svc,
                                                input logic [31:0] pl);
        return {src, tgt, id, svc, pl};
    endfunction

    task automatic enqueue(input logic [1:0] svc, input logic [15:0] tgt, input logic [31:0] pl);
        tx_valid_i   = 1'b1;
        tx_service_i = svc;
        tx_target_i  = tgt;
        tx_payload_i = pl;
        step();
        tx_valid_i   = 1'b0;
    endtask

    // Router side of one injection: wait for req, hold ack for two cycles, release
    task automatic router_serve(input logic [BR_DATA_W-1:0] exp, input int delay);
        int n = 0;
        while (!br_req_o && n < 50) begin
            step();
            n++;
        end
        check("tx_req_seen", br_req_o, 1);
        check("tx_flit", br_flit_o, exp);
        repeat (delay) step();
        check("tx_req_held", {br_req_o, br_flit_o}, {1'b1, exp});
        br_ack_i = 1'b1;
        step();
        check("tx_req_drop", br_req_o, 0);
        step();
        check("tx_wait_ack_high", br_req_o, 0);
        br_ack_i = 1'b0;
        step();
        check("tx_gap", br_req_o, 0);
    endtask

    // Router delivery: raise req, wait for ack, drop req, ack must fall next edge
    task automatic rx_deliver(input logic [BR_DATA_W-1:0] f);
        int n = 0;
        br_flit_i = f;
        br_req_i  = 1'b1;
        step();
        while (!br_ack_o && n < 20) begin
            step();
            n++;
        end
        check("rx_ack_seen", br_ack_o, 1);
        br_req_i = 1'b0;
        step();
        check("rx_ack_fall", br_ack_o, 0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        tx_valid_i      = 1'b0;
        tx_service_i    = '0;
        tx_target_i     = '0;
        tx_payload_i    = '0;
        rx_ready_i      = 1'b0;
        br_ack_i        = 1'b0;
        br_local_busy_i = 1'b0;
        br_flit_i       = '0;
        br_req_i        = 1'b0;
        repeat (3) step();
        check("rst_outputs",
              {tx_ready_o, tx_drop_o, rx_valid_o, br_req_o, br_ack_o, rx_data_o, br_flit_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {BR_DATA_W{1'b0}}, {BR_DATA_W{1'b0}}});
        rst_ni = 1'b1;
        step();

        // 1: single targeted injection, id 0
        enqueue(BR_SVC_TGT, 16'd9, 32'hAB);
        check("tx_latency", br_req_o, 0);
        router_serve(mk(16'd5, 16'd9, 8'd0, 2'd1, 32'hAB), 3);
        repeat (3) step();
        check("tx_single_pop", br_req_o, 0);

        // 2: busy holds off two queued requests, then they go out in order
        br_local_busy_i = 1'b1;
        enqueue(BR_SVC_ALL, 16'h10, 32'h11);
        enqueue(BR_SVC_MON, 16'h20, 32'h22);
        repeat (5) step();
        check("tx_busy_block", br_req_o, 0);
        br_local_busy_i = 1'b0;
        router_serve(mk(16'd5, 16'h10, 8'd1, 2'd0, 32'h11), 1);
        router_serve(mk(16'd5, 16'h20, 8'd2, 2'd2, 32'h22), 2);

        // 3: CLEAR is dropped with a one-cycle pulse
        check("drop_idle", tx_drop_o, 0);
        enqueue(BR_SVC_CLEAR, 16'h30, 32'h33);
        check("drop_pulse", tx_drop_o, 1);
        step();
        check("drop_one_cycle", tx_drop_o, 0);
        repeat (3) step();
        check("drop_no_req", {br_req_o, tx_ready_o}, {1'b0, 1'b1});

        // 4: targeted then broadcast delivery, each pushed once
        br_flit_i = mk(16'h1, 16'd5, 8'h7, 2'd1, 32'hCAFE);
        br_req_i  = 1'b1;
        step();
        check("rx_ack_1cyc", {br_ack_o, rx_valid_o}, {1'b1, 1'b1});
        check("rx_head_tgt", rx_data_o, mk(16'h1, 16'd5, 8'h7, 2'd1, 32'hCAFE));
        step();
        check("rx_ack_hold", br_ack_o, 1);
        br_req_i = 1'b0;
        step();
        check("rx_ack_fall_tgt", br_ack_o, 0);
        br_flit_i = mk(16'h2, 16'h0, 8'h8, 2'd0, 32'hBEEF);
        br_req_i  = 1'b1;
        step();
        check("rx_ack_bc", br_ack_o, 1);
        br_req_i = 1'b0;
        step();
        check("rx_ack_fall_bc", br_ack_o, 0);
        rx_ready_i = 1'b1;
        check("rx_pop1", rx_data_o, mk(16'h1, 16'd5, 8'h7, 2'd1, 32'hCAFE));
        step();
        check("rx_pop2", rx_data_o, mk(16'h2, 16'h0, 8'h8, 2'd0, 32'hBEEF));
        step();
        rx_ready_i = 1'b0;
        check("rx_no_dup", rx_valid_o, 0);

        // 5: backpressure on full RX FIFO
        rx_deliver(mk(16'h3, 16'h0, 8'h1, 2'd0, 32'h3333));
        rx_deliver(mk(16'h4, 16'h0, 8'h2, 2'd2, 32'h4444));
        br_flit_i = mk(16'h5, 16'h0, 8'h3, 2'd0, 32'h5555);
        br_req_i  = 1'b1;
        repeat (4) step();
        check("rx_full_no_ack", br_ack_o, 0);
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
        check("rx_pop_full_no_push", br_ack_o, 0);
        step();
        check("rx_capture_freed", br_ack_o, 1);
        br_req_i = 1'b0;
        step();
        check("rx_order_a", rx_data_o, mk(16'h4, 16'h0, 8'h2, 2'd2, 32'h4444));
        rx_ready_i = 1'b1;
        step();
        check("rx_order_b", rx_data_o, mk(16'h5, 16'h0, 8'h3, 2'd0, 32'h5555));
        step();
        rx_ready_i = 1'b0;
        check("rx_drained", rx_valid_o, 0);

        // 6: async reset mid-handshake
        enqueue(BR_SVC_ALL, 16'h1, 32'h66);
        enqueue(BR_SVC_ALL, 16'h2, 32'h77);
        br_flit_i = mk(16'h6, 16'h0, 8'h9, 2'd0, 32'h6666);
        br_req_i  = 1'b1;
        step();
        check("pre_rst_active", {br_req_o, br_ack_o}, {1'b1, 1'b1});
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_drop", {br_req_o, br_ack_o}, {1'b0, 1'b0});
        check("rst_fifos", {rx_valid_o, tx_ready_o, br_flit_o}, {1'b0, 1'b1, {BR_DATA_W{1'b0}}});
        br_req_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        repeat (3) step();
        check("rst_tx_empty", br_req_o, 0);
        enqueue(BR_SVC_TGT, 16'h44, 32'h99);
        router_serve(mk(16'd5, 16'h44, 8'd0, 2'd1, 32'h99), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
